// File: rtl/cheri_pkg.sv
// Shared CHERI types for the TBRE background revocation sweeper: capability metadata,
// sweep FSM encoding and slot geometry.
package cheri_pkg;

    localparam int TBRE_SLOT_BYTES = 8;

    typedef enum logic [2:0] {
        TBRE_IDLE      = 3'd0,
        TBRE_LD_REQ    = 3'd1,
        TBRE_LD_WAIT   = 3'd2,
        TBRE_TRVK_WAIT = 3'd3,
        TBRE_ST_REQ    = 3'd4,
        TBRE_ST_WAIT   = 3'd5,
        TBRE_NEXT      = 3'd6
    } tbre_sweep_state_e;

    typedef struct packed {
        logic        valid;
        logic [3:0]  otype;
        logic [11:0] perms;
        logic [8:0]  base;
        logic [8:0]  top;
    } reg_cap_t;

    localparam reg_cap_t NULL_REG_CAP = '0;

    // Write-back of a revoked slot keeps the metadata but drops the tag.
    function automatic reg_cap_t cap_clear_tag(input reg_cap_t c);
        reg_cap_t r;
        r       = c;
        r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/cheri_tbre_sweep_if.sv
// LSU request/response channel between the TBRE sweeper (master) and the LSU (slave).
interface cheri_tbre_sweep_if;

    logic                lsu_tbre_req_o;
    logic                lsu_tbre_is_wr_o;
    logic [31:0]         lsu_tbre_addr_o;
    logic [31:0]         lsu_tbre_wdata_o;
    cheri_pkg::reg_cap_t lsu_tbre_wcap_o;
    logic                lsu_tbre_req_done_i;
    logic                lsu_tbre_resp_valid_i;
    logic                lsu_tbre_resp_err_i;
    logic [31:0]         rf_wdata_lsu_i;
    cheri_pkg::reg_cap_t rf_wcap_lsu_i;

    modport master (
        output lsu_tbre_req_o, lsu_tbre_is_wr_o, lsu_tbre_addr_o, lsu_tbre_wdata_o, lsu_tbre_wcap_o,
        input  lsu_tbre_req_done_i, lsu_tbre_resp_valid_i, lsu_tbre_resp_err_i,
        input  rf_wdata_lsu_i, rf_wcap_lsu_i
    );

    modport slave (
        input  lsu_tbre_req_o, lsu_tbre_is_wr_o, lsu_tbre_addr_o, lsu_tbre_wdata_o, lsu_tbre_wcap_o,
        output lsu_tbre_req_done_i, lsu_tbre_resp_valid_i, lsu_tbre_resp_err_i,
        output rf_wdata_lsu_i, rf_wcap_lsu_i
    );

endinterface

// File: rtl/cheri_tbre_sweep.sv
// TBRE background revocation sweeper: load each slot, await the trvk verdict, write back
// revoked caps with the tag cleared. Optional tag-clear counter under CHERI_TBRE_STATS_EN.
module cheri_tbre_sweep import cheri_pkg::*; #(
    parameter int unsigned TrvkLatency = 3,
    parameter int unsigned WdtCycles   = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sweep_go_i,
    input  logic [31:0] sweep_start_i,
    input  logic [31:0] sweep_end_i,
    output logic        sweep_busy_o,
    output logic        sweep_done_o,
    output logic        sweep_err_o,
    cheri_tbre_sweep_if.master lsu,
    input  logic        tbre_trvk_en_i,
    input  logic        tbre_trvk_clrtag_i,
    input  logic        cpu_st_valid_i,
    input  logic [31:0] cpu_st_addr_i,
    output logic [31:0] sweep_nclr_o
);

    // A watchdog shorter than the verdict latency would abandon every slot.
    localparam int unsigned WdtLimit = (WdtCycles > TrvkLatency) ? WdtCycles : TrvkLatency + 1;
    localparam int unsigned WdtW     = $clog2(WdtLimit + 1);

    localparam logic [2:0] S_IDLE      = TBRE_IDLE;
    localparam logic [2:0] S_LD_REQ    = TBRE_LD_REQ;
    localparam logic [2:0] S_LD_WAIT   = TBRE_LD_WAIT;
    localparam logic [2:0] S_TRVK_WAIT = TBRE_TRVK_WAIT;
    localparam logic [2:0] S_ST_REQ    = TBRE_ST_REQ;
    localparam logic [2:0] S_ST_WAIT   = TBRE_ST_WAIT;
    localparam logic [2:0] S_NEXT      = TBRE_NEXT;

    localparam logic [31:0] SLOT_MASK = ~32'(TBRE_SLOT_BYTES - 1);

    logic [2:0]      state;
    logic [31:0]     cur_addr, end_addr, wdata, next_addr, go_start, go_end;
    reg_cap_t        wcap;
    logic            busy, done, err, snoop_hit, snoop_now;
    logic [WdtW-1:0] wdt;
    logic            unused_bits;

    assign go_start  = sweep_start_i & SLOT_MASK;
    assign go_end    = sweep_end_i & SLOT_MASK;
    assign next_addr = cur_addr + 32'(TBRE_SLOT_BYTES);
    assign snoop_now = cpu_st_valid_i && (cpu_st_addr_i[31:3] == cur_addr[31:3]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            end_addr  <= '0;
            wdata     <= '0;
            wcap      <= NULL_REG_CAP;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            snoop_hit <= 1'b0;
            wdt       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sweep_go_i) begin
                        cur_addr <= go_start;
                        end_addr <= go_end;
                        if (go_start >= go_end) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_LD_REQ;
                        end
                    end
                end
                S_LD_REQ: if (lsu.lsu_tbre_req_done_i) state <= S_LD_WAIT;
                S_LD_WAIT: begin
                    // Errored loads are captured too; trvk answers them with clrtag = 0.
                    if (lsu.lsu_tbre_resp_valid_i) begin
                        wdata     <= lsu.rf_wdata_lsu_i;
                        wcap      <= cap_clear_tag(lsu.rf_wcap_lsu_i);
                        snoop_hit <= snoop_now;
                        wdt       <= '0;
                        state     <= S_TRVK_WAIT;
                    end
                end
                S_TRVK_WAIT: begin
                    snoop_hit <= snoop_hit | snoop_now;
                    if (tbre_trvk_en_i) begin
                        // A same-cycle CPU store also counts: never clobber newer data.
                        state <= (tbre_trvk_clrtag_i && !(snoop_hit || snoop_now)) ? S_ST_REQ : S_NEXT;
                    end else if (wdt == WdtW'(WdtLimit - 1)) begin
                        err   <= 1'b1;
                        state <= S_NEXT;
                    end else begin
                        wdt <= wdt + 1'b1;
                    end
                end
                S_ST_REQ:  if (lsu.lsu_tbre_req_done_i) state <= S_ST_WAIT;
                S_ST_WAIT: if (lsu.lsu_tbre_resp_valid_i) state <= S_NEXT;
                S_NEXT: begin
                    cur_addr <= next_addr;
                    if (next_addr >= end_addr || next_addr == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_LD_REQ;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CHERI_TBRE_STATS_EN
    logic [31:0] nclr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nclr <= '0;
        end else if (state == S_IDLE && sweep_go_i) begin
            nclr <= '0;
        end else if (state == S_ST_WAIT && lsu.lsu_tbre_resp_valid_i && nclr != '1) begin
            nclr <= nclr + 1'b1;
        end
    end

    assign sweep_nclr_o = nclr;
`else
    assign sweep_nclr_o = '0;
`endif

    assign sweep_busy_o         = busy;
    assign sweep_done_o         = done;
    assign sweep_err_o          = err;
    assign lsu.lsu_tbre_req_o   = (state == S_LD_REQ) || (state == S_ST_REQ);
    assign lsu.lsu_tbre_is_wr_o = (state == S_ST_REQ);
    assign lsu.lsu_tbre_addr_o  = cur_addr;
    assign lsu.lsu_tbre_wdata_o = wdata;
    assign lsu.lsu_tbre_wcap_o  = wcap;

    assign unused_bits = ^{lsu.lsu_tbre_resp_err_i, cpu_st_addr_i[2:0],
                           sweep_start_i[2:0], sweep_end_i[2:0]};

    // The LSU must accept a request before responding to it.
    resp_after_accept: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (lsu.lsu_tbre_req_o && !lsu.lsu_tbre_req_done_i) |-> !lsu.lsu_tbre_resp_valid_i);

endmodule
